// File: rtl/bp_pkg.sv
// bp_pkg: shared constants and saturating-counter helpers for the branch predictor.
package bp_pkg;
  localparam int DEF_BTB_ENTRIES = 16;
  localparam int DEF_PHT_ENTRIES = 64;
  localparam int DEF_BTB_IDX_W = $clog2(DEF_BTB_ENTRIES);
  localparam int DEF_PHT_IDX_W = $clog2(DEF_PHT_ENTRIES);
  function automatic logic [3:0] cnt_reset(int unsigned bits);
    return 4'((1 << (bits - 1)) - 1);
  endfunction
  function automatic logic [3:0] cnt_inc(logic [3:0] c, int unsigned bits);
    return (c == 4'((1 << bits) - 1)) ? c : c + 4'd1;
  endfunction
  function automatic logic [3:0] cnt_dec(logic [3:0] c);
    return (c == 4'd0) ? c : c - 4'd1;
  endfunction
endpackage

// File: rtl/branch_predictor_sat_counter_array.sv
// sat_counter_array: flop array of saturating counters with one read and one update port.
module sat_counter_array
  import bp_pkg::*;
#(
  parameter int DEPTH = DEF_PHT_ENTRIES,
  parameter int WIDTH = 2,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_cnt,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic             wr_inc
);
  logic [WIDTH-1:0] cnt_q [DEPTH];
  logic [WIDTH-1:0] cnt_d [DEPTH];
  logic [3:0] cur;
  always_comb begin
    cnt_d = cnt_q;
    cur = 4'(cnt_q[wr_idx]);
    if (wr_en) cnt_d[wr_idx] = WIDTH'(wr_inc ? cnt_inc(cur, WIDTH) : cnt_dec(cur));
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) cnt_q[i] <= rst ? WIDTH'(cnt_reset(WIDTH)) : cnt_d[i];
  end
  assign rd_cnt = cnt_q[rd_idx];
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: tagged direct-mapped BTB plus bimodal/gshare PHT, combinational lookup, ID-stage update.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int BTB_ENTRIES = DEF_BTB_ENTRIES,
  parameter int PHT_ENTRIES = DEF_PHT_ENTRIES,
  parameter int CNT_BITS = 2,
  parameter int HIST_BITS = 0,
  parameter int PERF_BITS = 16,
  localparam int BW = $clog2(BTB_ENTRIES),
  localparam int PW = $clog2(PHT_ENTRIES),
  localparam int TW = 30 - BW,
  localparam int GW = (HIST_BITS > 0) ? HIST_BITS : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          if_pc,
  output logic                 predict_taken,
  output logic [31:0]          predict_PC,
  output logic [PW-1:0]        pred_pht_idx,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic [PW-1:0]        upd_pht_idx,
  input  logic                 upd_taken,
  input  logic [31:0]          upd_target,
  input  logic                 upd_mispredict,
  output logic [PERF_BITS-1:0] mispredict_cnt
);
  logic          btb_valid_q  [BTB_ENTRIES];
  logic          btb_valid_d  [BTB_ENTRIES];
  logic [TW-1:0] btb_tag_q    [BTB_ENTRIES];
  logic [TW-1:0] btb_tag_d    [BTB_ENTRIES];
  logic [31:0]   btb_target_q [BTB_ENTRIES];
  logic [31:0]   btb_target_d [BTB_ENTRIES];
  logic [GW-1:0] ghr_q, ghr_d;
  logic [PERF_BITS-1:0] perf_q, perf_d;
  logic [BW-1:0] bi, ui;
  logic [CNT_BITS-1:0] pht_cnt;
  logic hit;
  logic unused_bits;
  assign bi = if_pc[BW+1:2];
  assign ui = upd_pc[BW+1:2];
  assign pred_pht_idx = if_pc[PW+1:2] ^ PW'(ghr_q);
  assign hit = btb_valid_q[bi] && (btb_tag_q[bi] == if_pc[31:BW+2]);
  assign predict_taken = hit && pht_cnt[CNT_BITS-1];
  assign predict_PC = predict_taken ? btb_target_q[bi] : if_pc + 32'd4;
  assign mispredict_cnt = perf_q;
  assign unused_bits = &{1'b0, if_pc[1:0], upd_pc[1:0], pht_cnt};
  sat_counter_array #(.DEPTH(PHT_ENTRIES), .WIDTH(CNT_BITS)) u_pht (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (pred_pht_idx),
    .rd_cnt (pht_cnt),
    .wr_en  (upd_valid),
    .wr_idx (upd_pht_idx),
    .wr_inc (upd_taken)
  );
  // A taken update writes the whole entry, so hit-refresh and miss-allocate collapse to one path.
  always_comb begin
    btb_valid_d = btb_valid_q;
    btb_tag_d = btb_tag_q;
    btb_target_d = btb_target_q;
    if (upd_valid && upd_taken) begin
      btb_valid_d[ui] = 1'b1;
      btb_tag_d[ui] = upd_pc[31:BW+2];
      btb_target_d[ui] = upd_target;
    end
    ghr_d = (HIST_BITS > 0 && upd_valid) ? GW'({ghr_q, upd_taken}) : ghr_q;
    perf_d = (upd_valid && upd_mispredict && !(&perf_q)) ? perf_q + 1'b1 : perf_q;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < BTB_ENTRIES; i++) btb_valid_q[i] <= rst ? 1'b0 : btb_valid_d[i];
    ghr_q <= rst ? '0 : ghr_d;
    perf_q <= rst ? '0 : perf_d;
  end
  always_ff @(posedge clk) begin
    btb_tag_q <= btb_tag_d;
    btb_target_q <= btb_target_d;
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench driving a bimodal and a gshare/4-bit-perf instance with one stimulus stream.
module tb_branch_predictor;
  logic clk = 0;
  logic rst = 0;
  logic [31:0] if_pc = 0, upd_pc = 0, upd_target = 0;
  logic upd_valid = 0, upd_taken = 0, upd_mispredict = 0;
  logic [5:0] uidx0 = 0, uidx1 = 0;
  logic pt0, pt1;
  logic [31:0] ppc0, ppc1;
  logic [5:0] pidx0, pidx1;
  logic [15:0] mc0;
  logic [3:0] mc1;
  int checks = 0, errors = 0;
  bit armed = 0;

  always #5 clk = ~clk;

  branch_predictor dut0 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .predict_taken(pt0), .predict_PC(ppc0),
    .pred_pht_idx(pidx0), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_pht_idx(uidx0),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .mispredict_cnt(mc0)
  );
  branch_predictor #(.HIST_BITS(2), .PERF_BITS(4)) dut1 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .predict_taken(pt1), .predict_PC(ppc1),
    .pred_pht_idx(pidx1), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_pht_idx(uidx1),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .mispredict_cnt(mc1)
  );

  // Reference model: instance k has 16 BTB entries, 64 PHT 2-bit counters, history length 0 or 2.
  int unsigned m_pht [2][64];
  bit          m_v   [2][16];
  int unsigned m_tag [2][16];
  int unsigned m_tgt [2][16];
  int unsigned m_ghr [2];
  int unsigned m_mc  [2];

  typedef struct {
    logic pt [2];
    logic [31:0] ppc [2];
    logic [5:0] idx [2];
    int unsigned mc [2];
  } exp_t;
  exp_t sbq [$];

  function automatic int unsigned m_pi(int k, logic [31:0] pc);
    return ((pc >> 2) % 64) ^ m_ghr[k];
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) m_pht[k][i] = 1;
      for (int i = 0; i < 16; i++) m_v[k][i] = 0;
      m_ghr[k] = 0;
      m_mc[k] = 0;
    end
  endtask

  task automatic m_update(int k, int unsigned idx, logic [31:0] pc, bit t, logic [31:0] tgt, bit mis);
    int unsigned b;
    b = (pc >> 2) % 16;
    if (t && m_pht[k][idx] < 3) m_pht[k][idx]++;
    if (!t && m_pht[k][idx] > 0) m_pht[k][idx]--;
    if (t) begin
      m_v[k][b] = 1;
      m_tag[k][b] = pc >> 6;
      m_tgt[k][b] = tgt;
    end
    if (k == 1) m_ghr[k] = ((m_ghr[k] << 1) | int'(t)) % 4;
    if (mis && m_mc[k] < ((k == 0) ? 65535 : 15)) m_mc[k]++;
  endtask

  task automatic cyc(bit r, logic [31:0] ipc, bit uv, logic [31:0] upc, bit ut, logic [31:0] utgt, bit um);
    exp_t e;
    int unsigned b, p;
    rst = r; if_pc = ipc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_target = utgt; upd_mispredict = um;
    uidx0 = 6'(m_pi(0, upc));
    uidx1 = 6'(m_pi(1, upc));
    if (armed) begin
      b = (ipc >> 2) % 16;
      for (int k = 0; k < 2; k++) begin
        p = m_pi(k, ipc);
        e.pt[k] = m_v[k][b] && m_tag[k][b] == (ipc >> 6) && m_pht[k][p] >= 2;
        e.ppc[k] = e.pt[k] ? m_tgt[k][b] : ipc + 32'd4;
        e.idx[k] = 6'(p);
        e.mc[k] = m_mc[k];
      end
      sbq.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      m_reset();
      armed = 1;
    end else if (uv) begin
      m_update(0, uidx0, upc, ut, utgt, um);
      m_update(1, uidx1, upc, ut, utgt, um);
    end
    #1;
  endtask

  task automatic cmp(string n, logic [31:0] a, logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", n, a, x, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      cmp("pt0", 32'(pt0), 32'(e.pt[0]));
      cmp("ppc0", ppc0, e.ppc[0]);
      cmp("idx0", 32'(pidx0), 32'(e.idx[0]));
      cmp("mc0", 32'(mc0), e.mc[0]);
      cmp("pt1", 32'(pt1), 32'(e.pt[1]));
      cmp("ppc1", ppc1, e.ppc[1]);
      cmp("idx1", 32'(pidx1), 32'(e.idx[1]));
      cmp("mc1", 32'(mc1), e.mc[1]);
    end
  end

  function automatic logic [31:0] rnd_pc();
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 1)) << 20);
  endfunction

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h100, 0, 0, 0, 0, 0);
    cyc(0, 32'h100, 0, 0, 0, 0, 0);
    cyc(0, 32'h100, 1, 32'h100, 1, 32'h200, 1);
    cyc(0, 32'h100, 0, 0, 0, 0, 0);
    cyc(0, 32'h140, 0, 0, 0, 0, 0);
    cyc(0, 32'h140, 1, 32'h140, 1, 32'h300, 0);
    cyc(0, 32'h100, 0, 0, 0, 0, 0);
    cyc(0, 32'h140, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 32'h100, 1, 32'h100, 1, 32'h200, 0);
    cyc(0, 32'h100, 0, 0, 0, 0, 0);
    cyc(0, 32'h100, 1, 32'h100, 0, 32'h0, 1);
    cyc(0, 32'h100, 0, 0, 0, 0, 0);
    cyc(0, 32'h100, 1, 32'h100, 0, 32'h0, 1);
    cyc(0, 32'h100, 0, 0, 0, 0, 0);
    cyc(0, 32'h100, 1, 32'h104, 1, 32'h400, 0);
    cyc(0, 32'h100, 1, 32'h104, 1, 32'h400, 0);
    cyc(0, 32'h100, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 32'h104, 1, 32'h108, 0, 0, 1);
    cyc(0, 32'h104, 0, 32'h108, 0, 0, 1);
    cyc(0, 32'h104, 0, 0, 0, 0, 0);
    cyc(1, 32'h100, 1, 32'h100, 1, 32'h200, 1);
    cyc(0, 32'h100, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a, u;
      a = rnd_pc();
      u = ($urandom_range(0, 1) == 1) ? a : rnd_pc();
      cyc($urandom_range(0, 199) == 0, a, $urandom_range(0, 3) != 0, u,
          $urandom_range(0, 2) != 0, $urandom & 32'hffff_fffc, $urandom_range(0, 1) == 1);
    end
    cyc(0, 32'h100, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d required 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
